// File: rtl/fir_pkg.sv
// Shared types and constants for the symmetric FIR: FSM states, accumulator sizing, default taps.
// The default taps are the ones used by the 8-tap DAC low-pass.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } fir_state_t;

  // Wide enough for HALF products of a signed coefficient and a doubled unsigned sample.
  function automatic int fir_acc_width(input int cw, input int dw, input int half);
    return cw + dw + 2 + $clog2(half);
  endfunction

  // Unique half of the coefficient set. Index 0 is the outermost tap.
  // TAPS=8 sums to 1000, giving a DC gain of 1000/1024 with SHIFT=10.
  // Any other length falls back to a flat box filter of roughly unity gain.
  function automatic int fir_default_coef(input int taps, input int k);
    if (taps == 8) begin
      case (k)
        0:       return 9;
        1:       return 48;
        2:       return 164;
        default: return 279;
      endcase
    end
    return 1024 / taps;
  endfunction

endpackage

// File: rtl/fir_sample_tick.sv
// Free-running sample-rate divider: one-cycle sample_tick when the count reaches DIV-1.
module fir_sample_tick #(
  parameter int DIV = 500
) (
  input  logic clk,
  input  logic reset,
  output logic sample_tick
);

  localparam int CNTW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNTW'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sample_tick = (r_cnt == CNTW'(DIV - 1));

endmodule

// File: rtl/fir_symm_mac.sv
// Symmetric-coefficient FIR with one shared pre-add/multiply/accumulate datapath, one tap pair per cycle.
// Define FIR_COEF_WR_EN to add run-time coefficient writes through a shadow bank.
module fir_symm_mac
  import fir_pkg::*;
#(
  parameter int DW    = 10,
  parameter int CW    = 12,
  parameter int TAPS  = 8,
  parameter int SHIFT = 10,
  parameter int DIV   = 500,
  localparam int HALF = (TAPS + 1) / 2,
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
`ifdef FIR_COEF_WR_EN
  input  logic          coef_wr_en,
  input  logic [AW-1:0] coef_wr_addr,
  input  logic [CW-1:0] coef_wr_data,
`endif
  output logic          sample_tick,
  output logic          busy,
  output logic [DW-1:0] fir_data,
  output logic          fir_valid,
  output logic          sat_flag,
  output fir_state_t    dbg_state
);

  localparam int ACCW = fir_acc_width(CW, DW, HALF);
  localparam int PW   = DW + 1;
  localparam int XW   = $clog2(TAPS);
  localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** DW) - 1);

  if (TAPS < 2 || TAPS > 64) begin : g_bad_taps
    $error("fir_symm_mac: TAPS must be in 2..64");
  end
  if (DIV < HALF + 3) begin : g_bad_div
    $error("fir_symm_mac: DIV must be at least HALF+3");
  end

  logic w_tick;

  fir_sample_tick #(.DIV(DIV)) u_tick (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (w_tick)
  );

  logic [DW-1:0] r_x [TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else if (w_tick) begin
      r_x[0] <= data_in;
      for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
    end
  end

  logic signed [CW-1:0] w_coef [HALF];

`ifdef FIR_COEF_WR_EN
  logic signed [CW-1:0] r_shadow [HALF];
  logic signed [CW-1:0] r_active [HALF];

  // Writes go to the shadow bank at any time; the active bank only follows at a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HALF; i++) begin
        r_shadow[i] <= CW'(fir_default_coef(TAPS, i));
        r_active[i] <= CW'(fir_default_coef(TAPS, i));
      end
    end else begin
      if (coef_wr_en && (int'(coef_wr_addr) < HALF)) r_shadow[coef_wr_addr] <= coef_wr_data;
      if (w_tick) r_active <= r_shadow;
    end
  end

  always_comb begin
    for (int i = 0; i < HALF; i++) w_coef[i] = r_active[i];
  end
`else
  always_comb begin
    for (int i = 0; i < HALF; i++) w_coef[i] = CW'(fir_default_coef(TAPS, i));
  end
`endif

  fir_state_t r_state, w_next;
  logic [AW-1:0] r_k;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_next = MAC;
      MAC:     if (r_k == AW'(HALF - 1)) w_next = SCALE;
      SCALE:   w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  logic [XW-1:0]             w_lo, w_hi;
  logic [PW-1:0]             w_pre;
  logic signed [CW+PW:0]     w_prod;
  logic signed [ACCW-1:0]    r_acc, w_s;
  logic [DW-1:0]             w_clamp;
  logic                      w_sat;

  // Odd lengths have an unpaired centre tap, which must not be doubled.
  always_comb begin
    w_lo  = XW'(r_k);
    w_hi  = XW'(TAPS - 1) - w_lo;
    w_pre = PW'(r_x[w_lo]) + PW'(r_x[w_hi]);
    if ((TAPS % 2 == 1) && (w_lo == XW'(HALF - 1))) w_pre = PW'(r_x[w_lo]);
    w_prod = w_coef[r_k] * $signed({1'b0, w_pre});
  end

  always_comb begin
    w_s     = r_acc >>> SHIFT;
    w_clamp = DW'(w_s);
    w_sat   = 1'b0;
    if (w_s < 0) begin
      w_clamp = '0;
      w_sat   = 1'b1;
    end else if (w_s > MAXV) begin
      w_clamp = '1;
      w_sat   = 1'b1;
    end
  end

  logic [DW-1:0] r_fir_data;
  logic          r_fir_valid;
  logic          r_sat;

  // The result is registered on leaving SCALE so fir_valid is high exactly while in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k         <= '0;
      r_acc       <= '0;
      r_fir_data  <= '0;
      r_fir_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_fir_valid <= 1'b0;
      r_sat       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        MAC: begin
          r_acc <= r_acc + ACCW'(w_prod);
          r_k   <= r_k + 1'b1;
        end
        SCALE: begin
          r_fir_data  <= w_clamp;
          r_sat       <= w_sat;
          r_fir_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sample_tick = w_tick;
  assign busy        = (r_state != IDLE);
  assign fir_data    = r_fir_data;
  assign fir_valid   = r_fir_valid;
  assign sat_flag    = r_sat;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fir_symm_mac.sv
// Directed bench for fir_symm_mac: impulse, DC, latency, coefficient writes, saturation, mid-MAC reset.
module tb_fir_symm_mac;
  import fir_pkg::*;

  localparam int DW = 10;
  localparam int CW = 12;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
`ifdef FIR_COEF_WR_EN
  logic          coef_wr_en;
  logic [AW-1:0] coef_wr_addr;
  logic [CW-1:0] coef_wr_data;
`endif
  logic          sample_tick;
  logic          busy;
  logic [DW-1:0] fir_data;
  logic          fir_valid;
  logic          sat_flag;
  fir_state_t    dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_tick_cyc = -1;

  fir_symm_mac dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
`ifdef FIR_COEF_WR_EN
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
`endif
    .sample_tick  (sample_tick),
    .busy         (busy),
    .fir_data     (fir_data),
    .fir_valid    (fir_valid),
    .sat_flag     (sat_flag),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

`ifdef FIR_COEF_WR_EN
  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = AW'(addr);
    coef_wr_data = CW'(val);
    @(negedge clk);
    coef_wr_en   = 1'b0;
  endtask
`endif

  // Present din until the next tick, then collect that sample's output.
  // With wr_mid set, c[3] is written to 0 on the cycle after the tick.
  task automatic run_sample(input int din, input bit wr_mid, output int dout, output int dsat);
    int n;
    data_in = DW'(din);
    n = 0;
    @(negedge clk);
    while (!sample_tick && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!sample_tick) begin
      check_eq("tick_timeout", 0, 1);
      dout = -1;
      dsat = -1;
      return;
    end
    if (last_tick_cyc >= 0) check_eq("tick_period", cyc - last_tick_cyc, 500);
    last_tick_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
`ifdef FIR_COEF_WR_EN
      if (wr_mid && n == 1) begin
        check_eq("busy_at_wr", int'(busy), 1);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(3);
        coef_wr_data = '0;
      end else begin
        coef_wr_en = 1'b0;
      end
`endif
    end while (!fir_valid && n < 20);
    check_eq("latency", n, 6);
    dout = int'(fir_data);
    dsat = int'(sat_flag);
    @(negedge clk);
    check_eq("valid_pulse", int'(fir_valid), 0);
    check_eq("sat_pulse", int'(sat_flag), 0);
  endtask

  int imp_exp [10] = '{8, 46, 160, 272, 272, 160, 46, 8, 0, 0};

  initial begin
    int d, s, n;
    bit seen_valid;
    reset   = 1'b1;
    data_in = '0;
`ifdef FIR_COEF_WR_EN
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_fir_data", int'(fir_data), 0);
    check_eq("rst_fir_valid", int'(fir_valid), 0);
    check_eq("rst_sat_flag", int'(sat_flag), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_tick", int'(sample_tick), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_sample((i == 0) ? 1000 : 0, 1'b0, d, s);
      check_eq($sformatf("impulse_%0d", i), d, imp_exp[i]);
      check_eq($sformatf("impulse_sat_%0d", i), s, 0);
    end

    for (int i = 0; i < 10; i++) begin
      run_sample(1023, 1'b0, d, s);
      if (i >= 7) begin
        check_eq($sformatf("dc_%0d", i), d, 999);
        check_eq($sformatf("dc_sat_%0d", i), s, 0);
      end
    end

`ifdef FIR_COEF_WR_EN
    run_sample(1023, 1'b1, d, s);
    check_eq("shadow_cur", d, 999);
    run_sample(1023, 1'b0, d, s);
    check_eq("shadow_next", d, 441);

    for (int i = 0; i < 4; i++) write_coef(i, 300);
    run_sample(1023, 1'b0, d, s);
    check_eq("sat_hi", d, 1023);
    check_eq("sat_hi_flag", s, 1);

    write_coef(0, -200);
    for (int i = 1; i < 4; i++) write_coef(i, 0);
    run_sample(500, 1'b0, d, s);
    check_eq("sat_lo", d, 0);
    check_eq("sat_lo_flag", s, 1);
`endif

    data_in = DW'(1000);
    n = 0;
    @(negedge clk);
    while (!sample_tick && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_tick_seen", int'(sample_tick), 1);
    repeat (2) @(negedge clk);
    check_eq("rst_mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fir_valid) seen_valid = 1'b1;
    end
    check_eq("rst_mid_no_valid", int'(seen_valid), 0);
    check_eq("rst_mid_fir_data", int'(fir_data), 0);
    check_eq("rst_mid_sat", int'(sat_flag), 0);
    check_eq("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    last_tick_cyc = -1;

    run_sample(1000, 1'b0, d, s);
    check_eq("post_rst_first", d, 8);
    check_eq("post_rst_sat", s, 0);
    run_sample(0, 1'b0, d, s);
    check_eq("post_rst_second", d, 46);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
